uart_sender: RTL



---
 rtl/felis_uart_pkg.sv | 14 +
 rtl/uart_byte_fifo.sv | 59 +++++
 rtl/uart_sender.sv | 125 ++++++++++++
 3 files changed

// File: rtl/felis_uart_pkg.sv
// Shared definitions for the felis serial link (transmit and receive sides).
package felis_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with push/pop, occupancy count, full and empty flags.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LOG:0]     count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [LOG:0] DEPTH = {1'b1, {LOG{1'b0}}};

    logic [WIDTH-1:0] mem_q [2**LOG];
    logic [LOG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LOG:0]     count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Push is gated on full alone: a push at full is dropped even when a pop frees a slot.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + LOG'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + LOG'(1);
        if (do_push && !do_pop)      count_d = count_q + (LOG+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (LOG+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter: byte buffer feeding a framer FSM with a registered serial line.
module uart_sender
    import felis_uart_pkg::*;
#(
    parameter int INTERVAL = 868,
    parameter int BUF_LOG  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               uart_tx,
    output logic               busy,
    output logic [BUF_LOG:0]   count,
    output logic [1:0]         dbg_state
);
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INTERVAL - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    // Handshake: a byte is transferred on every rising edge where in_valid && in_ready.
    tx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   pop;
    logic                   fifo_full, fifo_empty;
    logic [7:0]             head;
    logic                   bit_end;

    uart_byte_fifo #(
        .WIDTH (8),
        .LOG   (BUF_LOG)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_tx   = tx_q;
    assign dbg_state = state_q;
    assign bit_end   = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) state_d = ST_STOP;
                    else                   bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                // Reload straight into START so consecutive frames have no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line flop follows the next-state values so each bit lines up with its state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
